pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Game-level sequencer for the Pong datapath. Owns the match state machine, both score
//  counters, the per-paddle hit-flash timers, and the serve/ball-reset sequencing.
//  Sits between the ball/paddle motion logic and the color mapper.
//  Drives scoreL/scoreR, nGame, eGame and paddle1Hit/paddle2Hit to the mapper.
//  Drives play_en, ball_reset and serve_dir to the ball module.
// PARAMETERS
//  WIN_SCORE     9    score that ends the match; range 1..9 (digit ROM holds 0-9)
//  SERVE_FRAMES  60   frame ticks the ball is held at centre before each serve
//  POINT_FRAMES  30   frame ticks of pause after a point, before the next serve
//  HIT_FRAMES    8    frame ticks a paddle shows red after contact
// PORTS
//  Clk             in   1  system clock
//  Reset_n         in   1  asynchronous, active-low reset
//  frame_tick      in   1  one-Clk pulse per frame (rising edge of frame_clk)
//  start_key       in   1  level from keyboard decode; acted on at its rising edge only
//  ball_exit_l     in   1  one-Clk pulse: ball passed the left wall (right player scores)
//  ball_exit_r     in   1  one-Clk pulse: ball passed the right wall (left player scores)
//  paddle1_contact in   1  one-Clk pulse: ball bounced off paddle 1
//  paddle2_contact in   1  one-Clk pulse: ball bounced off paddle 2
//  scoreL          out  4  left score, 0..WIN_SCORE
//  scoreR          out  4  right score, 0..WIN_SCORE
//  nGame           out  1  high in S_NEW (new-game screen)
//  eGame           out  1  high in S_OVER (end-game screen)
//  paddle1Hit      out  1  paddle 1 flash active
//  paddle2Hit      out  1  paddle 2 flash active
//  play_en         out  1  ball/paddle motion enabled; high only in S_PLAY
//  ball_reset      out  1  hold ball at centre; high in S_NEW, S_SERVE, S_POINT, S_OVER
//  serve_dir       out  1  0 = serve toward left, 1 = serve toward right
// BEHAVIOUR
//  Reset values
//   - State S_NEW; scores 0; nGame=1; eGame=0.
//   - Flash timers 0; play_en=0; ball_reset=1; serve_dir=1.
//  Outputs and edge detect
//   - All outputs are registered. Each responds on the Clk edge after the causing input.
//   - start_key is edge-detected with a 1-flop history, so one press yields one event.
//     The history flop resets to 1, so a key already held during reset does not fire.
//  State transitions
//   - S_NEW: start_rise -> S_SERVE. Scores clear to 0 and serve_dir=1 on entry.
//   - S_SERVE: frame counter loads 0 on entry. At count==SERVE_FRAMES-1 with
//     frame_tick -> S_PLAY.
//   - S_PLAY, ball_exit_l alone:
//       scoreR++; serve_dir=0 (serve toward the player who lost the point).
//       If new scoreR==WIN_SCORE -> S_OVER, else -> S_POINT.
//   - S_PLAY, ball_exit_r alone: the mirror case (scoreL++, serve_dir=1).
//   - S_PLAY, both exits in the same cycle: void point. No score change; -> S_POINT.
//   - S_POINT: after POINT_FRAMES frame ticks -> S_SERVE.
//   - S_OVER: scores hold. start_rise -> S_NEW.
//  Input gating
//   - start_rise outside S_NEW/S_OVER is ignored.
//   - Exit and contact pulses outside S_PLAY are ignored.
//  Score width
//   - Scores saturate at WIN_SCORE.
//   - The increment compares the pre-incremented value against WIN_SCORE-1, so there
//     is no 4-bit wrap.
//  Frame counter
//   - Single counter, $clog2(max(SERVE_FRAMES,POINT_FRAMES)) bits.
//   - Cleared on every state change; advances only on frame_tick.
//  Hit flash
//   - paddleN_contact in S_PLAY loads the timer with HIT_FRAMES.
//   - The timer decrements on frame_tick while nonzero. paddleNHit = (timer != 0).
//   - A contact and a frame_tick in the same cycle: the load wins.
//   - A retrigger while active reloads the timer; it does not accumulate.
//   - Both timers clear on any exit from S_PLAY.
//  Reset mid-operation
//   - Asserting Reset_n low in any state returns everything to the reset values at once.
// STRUCTURE
//  Package pong_pkg
//   - game_state_t enum: S_NEW, S_SERVE, S_PLAY, S_POINT, S_OVER.
//   - SCORE_W=4 and the default frame constants.
//  Sub-module hit_flash_timer (params HIT_FRAMES)
//   - Ports: Clk, Reset_n, frame_tick, load, clear -> active.
//   - Instantiated twice, once per paddle.
//  The top level holds the FSM, frame counter, scores and start edge detect.
// TESTING
//  T1 Reset, then start_key high for 3 cycles -> one S_SERVE entry.
//     nGame falls the next cycle. play_en rises after exactly 60 frame_ticks.
//  T2 In S_PLAY, pulse ball_exit_r -> next cycle scoreL=1, play_en=0, serve_dir=1.
//     After 30 + 60 ticks, play_en=1 again.
//  T3 scoreR=8, pulse ball_exit_l -> scoreR=9, eGame=1, ball_reset=1.
//     Further exit pulses leave scoreR=9. start_rise -> nGame=1, scores 0.
//  T4 paddle1_contact -> paddle1Hit high for 8 ticks.
//     A retrigger at tick 5 extends the flash to tick 13.
//     Contact and frame_tick in the same cycle -> the load wins.
//  T5 ball_exit_l and ball_exit_r in the same cycle -> scores unchanged; enters S_POINT.
//  T6 Reset_n low during S_PLAY with paddle2Hit active -> next sampled outputs:
//     nGame=1, paddle2Hit=0, scores 0, play_en=0.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared types and default constants for the Pong game controller.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int SCORE_W          = 4;
    localparam int WIN_SCORE_DEF    = 9;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 30;
    localparam int HIT_FRAMES_DEF   = 8;

    typedef enum logic [2:0] {
        S_NEW   = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } game_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hit_flash_timer.sv
`default_nettype none
// ============================================================================
// Module   : hit_flash_timer
// Purpose  : Frame-based countdown that keeps a paddle flash lit after contact.
// Revision : 1.0 - initial release
// ============================================================================
module hit_flash_timer #(
    parameter int HIT_FRAMES = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_tick,
    input  logic load,
    input  logic clear,
    output logic active
);

    localparam int TMR_W = $clog2(HIT_FRAMES + 1);

    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic             r_active;

    // Clear beats load (leaving play), load beats the frame decrement.
    always_comb begin
        w_timer_next = r_timer;
        if (clear) begin
            w_timer_next = '0;
        end else if (load) begin
            w_timer_next = TMR_W'(HIT_FRAMES);
        end else if (frame_tick && (r_timer != '0)) begin
            w_timer_next = r_timer - TMR_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_timer  <= '0;
            r_active <= 1'b0;
        end else begin
            r_timer  <= w_timer_next;
            r_active <= (w_timer_next != '0);
        end
    end

    assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Match sequencer: FSM, scores, serve timing and paddle hit flashes.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int HIT_FRAMES   = HIT_FRAMES_DEF
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic               start_key,
    input  logic               ball_exit_l,
    input  logic               ball_exit_r,
    input  logic               paddle1_contact,
    input  logic               paddle2_contact,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic               nGame,
    output logic               eGame,
    output logic               paddle1Hit,
    output logic               paddle2Hit,
    output logic               play_en,
    output logic               ball_reset,
    output logic               serve_dir
);

    localparam int CNT_MAX = max_int(SERVE_FRAMES, POINT_FRAMES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    game_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [SCORE_W-1:0] r_score_l, w_score_l_next;
    logic [SCORE_W-1:0] r_score_r, w_score_r_next;
    logic               r_serve_dir, w_serve_dir_next;
    logic               r_start_d;
    logic               r_ngame, r_egame, r_play_en, r_ball_reset;
    logic               w_start_rise;
    logic               w_in_play;
    logic               w_leave_play;

    assign w_start_rise = start_key & ~r_start_d;
    assign w_in_play    = (r_state == S_PLAY);
    assign w_leave_play = w_in_play && (w_state_next != S_PLAY);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_NEW;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_score_l_next   = r_score_l;
        w_score_r_next   = r_score_r;
        w_serve_dir_next = r_serve_dir;
        case (r_state)
            S_NEW: begin
                if (w_start_rise) begin
                    w_state_next     = S_SERVE;
                    w_score_l_next   = '0;
                    w_score_r_next   = '0;
                    w_serve_dir_next = 1'b1;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) w_state_next = S_PLAY;
                    else                                   w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            S_PLAY: begin
                // Ball is served toward the player who just lost the point.
                if (ball_exit_l && ball_exit_r) begin
                    w_state_next = S_POINT;
                end else if (ball_exit_l) begin
                    w_serve_dir_next = 1'b0;
                    if (r_score_r >= SCORE_W'(WIN_SCORE - 1)) begin
                        w_score_r_next = SCORE_W'(WIN_SCORE);
                        w_state_next   = S_OVER;
                    end else begin
                        w_score_r_next = r_score_r + SCORE_W'(1);
                        w_state_next   = S_POINT;
                    end
                end else if (ball_exit_r) begin
                    w_serve_dir_next = 1'b1;
                    if (r_score_l >= SCORE_W'(WIN_SCORE - 1)) begin
                        w_score_l_next = SCORE_W'(WIN_SCORE);
                        w_state_next   = S_OVER;
                    end else begin
                        w_score_l_next = r_score_l + SCORE_W'(1);
                        w_state_next   = S_POINT;
                    end
                end
            end
            S_POINT: begin
                if (frame_tick) begin
                    if (r_cnt == CNT_W'(POINT_FRAMES - 1)) w_state_next = S_SERVE;
                    else                                   w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_state_next     = S_NEW;
                    w_score_l_next   = '0;
                    w_score_r_next   = '0;
                    w_serve_dir_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_NEW;
            end
        endcase
        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt        <= '0;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_serve_dir  <= 1'b1;
            r_start_d    <= 1'b1;
            r_ngame      <= 1'b1;
            r_egame      <= 1'b0;
            r_play_en    <= 1'b0;
            r_ball_reset <= 1'b1;
        end else begin
            r_cnt        <= w_cnt_next;
            r_score_l    <= w_score_l_next;
            r_score_r    <= w_score_r_next;
            r_serve_dir  <= w_serve_dir_next;
            r_start_d    <= start_key;
            r_ngame      <= (w_state_next == S_NEW);
            r_egame      <= (w_state_next == S_OVER);
            r_play_en    <= (w_state_next == S_PLAY);
            r_ball_reset <= (w_state_next != S_PLAY);
        end
    end

    hit_flash_timer #(.HIT_FRAMES(HIT_FRAMES)) u_flash_p1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .load       (paddle1_contact & w_in_play),
        .clear      (w_leave_play),
        .active     (paddle1Hit)
    );

    hit_flash_timer #(.HIT_FRAMES(HIT_FRAMES)) u_flash_p2 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .load       (paddle2_contact & w_in_play),
        .clear      (w_leave_play),
        .active     (paddle2Hit)
    );

    assign scoreL     = r_score_l;
    assign scoreR     = r_score_r;
    assign nGame      = r_ngame;
    assign eGame      = r_egame;
    assign play_en    = r_play_en;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Directed vector bench for pong_game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_key = 1'b0;
    logic       ball_exit_l = 1'b0;
    logic       ball_exit_r = 1'b0;
    logic       paddle1_contact = 1'b0;
    logic       paddle2_contact = 1'b0;
    logic [3:0] scoreL, scoreR;
    logic       nGame, eGame, paddle1Hit, paddle2Hit, play_en, ball_reset, serve_dir;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_tick      (frame_tick),
        .start_key       (start_key),
        .ball_exit_l     (ball_exit_l),
        .ball_exit_r     (ball_exit_r),
        .paddle1_contact (paddle1_contact),
        .paddle2_contact (paddle2_contact),
        .scoreL          (scoreL),
        .scoreR          (scoreR),
        .nGame           (nGame),
        .eGame           (eGame),
        .paddle1Hit      (paddle1Hit),
        .paddle2Hit      (paddle2Hit),
        .play_en         (play_en),
        .ball_reset      (ball_reset),
        .serve_dir       (serve_dir)
    );

    always #5 Clk = ~Clk;

    // Packed view: {scoreL, scoreR, nGame, eGame, hit1, hit2, play_en, ball_reset, serve_dir}
    function automatic logic [14:0] pk(input int sl, input int sr, input logic ng, input logic eg,
                                       input logic h1, input logic h2, input logic pe,
                                       input logic br, input logic sd);
        return {4'(sl), 4'(sr), ng, eg, h1, h2, pe, br, sd};
    endfunction

    wire [14:0] outs = {scoreL, scoreR, nGame, eGame, paddle1Hit, paddle2Hit,
                        play_en, ball_reset, serve_dir};

    task automatic chk(input string name, input logic [14:0] got, input logic [14:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        chk(name, {14'd0, got}, {14'd0, exp});
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
        frame_tick      = 1'b0;
        ball_exit_l     = 1'b0;
        ball_exit_r     = 1'b0;
        paddle1_contact = 1'b0;
        paddle2_contact = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc();
        end
    endtask

    typedef struct {
        logic        start, exl, exr, p1, p2, tick;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[7];

    logic [14:0] c_rst, c_serve, c_play;

    initial begin
        c_rst   = pk(0, 0, 1, 0, 0, 0, 0, 1, 1);
        c_serve = pk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        c_play  = pk(0, 0, 0, 0, 0, 0, 1, 0, 1);

        // start held three cycles gives one serve; pulses/rises outside their states ignored
        vecs[0] = '{1, 0, 0, 0, 0, 0, c_serve};
        vecs[1] = '{1, 0, 0, 0, 0, 0, c_serve};
        vecs[2] = '{1, 0, 0, 0, 0, 0, c_serve};
        vecs[3] = '{0, 1, 0, 0, 0, 0, c_serve};
        vecs[4] = '{0, 0, 0, 1, 0, 0, c_serve};
        vecs[5] = '{1, 0, 0, 0, 0, 0, c_serve};
        vecs[6] = '{0, 0, 1, 0, 1, 0, c_serve};

        // Reset with the key already held must not start a game
        start_key = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_state", outs, c_rst);
        Reset_n = 1'b1;
        cyc();
        chk("held_key_no_fire", outs, c_rst);
        start_key = 1'b0;
        cyc();
        chk("idle_new", outs, c_rst);

        for (int i = 0; i < 7; i++) begin
            start_key       = vecs[i].start;
            ball_exit_l     = vecs[i].exl;
            ball_exit_r     = vecs[i].exr;
            paddle1_contact = vecs[i].p1;
            paddle2_contact = vecs[i].p2;
            frame_tick      = vecs[i].tick;
            cyc();
            chk($sformatf("vec%0d", i), outs, vecs[i].exp);
        end
        start_key = 1'b0;

        // T1: play enables after exactly 60 ticks
        ticks(59);
        chk("serve_59", outs, c_serve);
        ticks(1);
        chk("serve_60_play", outs, c_play);

        // T2: right exit scores left, pause 30 + serve 60
        ball_exit_r = 1'b1;
        cyc();
        chk("exit_r", outs, pk(1, 0, 0, 0, 0, 0, 0, 1, 1));
        ticks(89);
        chk("pause_89", outs, pk(1, 0, 0, 0, 0, 0, 0, 1, 1));
        ticks(1);
        chk("pause_90_play", outs, pk(1, 0, 0, 0, 0, 0, 1, 0, 1));

        // T4: flash length, retrigger, load-vs-tick
        paddle1_contact = 1'b1;
        cyc();
        chk("hit_load", outs, pk(1, 0, 0, 0, 1, 0, 1, 0, 1));
        ticks(7);
        chk("hit_7", outs, pk(1, 0, 0, 0, 1, 0, 1, 0, 1));
        ticks(1);
        chk("hit_8_off", outs, pk(1, 0, 0, 0, 0, 0, 1, 0, 1));
        paddle1_contact = 1'b1;
        cyc();
        ticks(5);
        paddle1_contact = 1'b1;
        cyc();
        ticks(7);
        chk("retrig_12", outs, pk(1, 0, 0, 0, 1, 0, 1, 0, 1));
        ticks(1);
        chk("retrig_13_off", outs, pk(1, 0, 0, 0, 0, 0, 1, 0, 1));
        paddle1_contact = 1'b1;
        cyc();
        ticks(3);
        paddle1_contact = 1'b1;
        frame_tick      = 1'b1;
        cyc();
        ticks(7);
        chk("loadwins_7", outs, pk(1, 0, 0, 0, 1, 0, 1, 0, 1));
        ticks(1);
        chk("loadwins_8_off", outs, pk(1, 0, 0, 0, 0, 0, 1, 0, 1));

        // T5: void point; flash cleared on leaving play
        paddle1_contact = 1'b1;
        cyc();
        ball_exit_l = 1'b1;
        ball_exit_r = 1'b1;
        cyc();
        chk("void_point", outs, pk(1, 0, 0, 0, 0, 0, 0, 1, 1));
        ticks(90);
        chk("void_replay", outs, pk(1, 0, 0, 0, 0, 0, 1, 0, 1));

        // T3: right player runs to the win score
        for (int i = 1; i <= 8; i++) begin
            ball_exit_l = 1'b1;
            cyc();
            chk($sformatf("score_r_%0d", i), outs, pk(1, i, 0, 0, 0, 0, 0, 1, 0));
            ticks(90);
        end
        chk("pre_win_play", outs, pk(1, 8, 0, 0, 0, 0, 1, 0, 0));
        ball_exit_l = 1'b1;
        cyc();
        chk("win", outs, pk(1, 9, 0, 1, 0, 0, 0, 1, 0));
        ball_exit_l = 1'b1;
        cyc();
        ball_exit_r = 1'b1;
        cyc();
        paddle1_contact = 1'b1;
        cyc();
        ticks(100);
        chk("over_hold", outs, pk(1, 9, 0, 1, 0, 0, 0, 1, 0));
        start_key = 1'b1;
        cyc();
        chk_bit("over_new_ngame", nGame, 1'b1);
        chk_bit("over_new_egame", eGame, 1'b0);
        chk("over_new_scores", {7'd0, scoreL, scoreR}, 15'd0);
        cyc();
        chk_bit("new_held_key", nGame, 1'b1);
        start_key = 1'b0;
        cyc();
        start_key = 1'b1;
        cyc();
        chk("restart_serve", outs, c_serve);
        start_key = 1'b0;
        ticks(60);
        chk("restart_play", outs, c_play);

        // T6: asynchronous reset during play with a flash active
        ball_exit_r = 1'b1;
        cyc();
        ticks(90);
        paddle2_contact = 1'b1;
        cyc();
        chk("pre_reset", outs, pk(1, 0, 0, 0, 0, 1, 1, 0, 1));
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_reset", outs, c_rst);
        @(posedge Clk);
        #1;
        chk("reset_held", outs, c_rst);
        Reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
